pipe_ctrl: RTL and testbench

Central pipeline sequencing controller for the five-stage RISC-V core. It merges stall requests from IF, ID (load-use) and MEM into the per-stage stall vector. It turns the ID-stage branch/jump decision into a registered PC redirect plus a one-cycle IF/ID flush, and keeps a stall watchdog and saturating performance counters. It sits beside the pipeline registers and drives their hold/flush inputs and the PC mux.

---
 rtl/pipe_ctrl_pkg.sv | 29 ++
 rtl/pipe_ctrl_if.sv | 26 ++
 rtl/pipe_ctrl_sat_counter.sv | 22 ++
 rtl/pipe_ctrl.sv | 107 ++++++++++
 tb/tb_pipe_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: stall encodings,
// controller states and the stall-vector priority decode.
package pipe_ctrl_pkg;

    localparam int unsigned STALL_W = 6;

    localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;
    localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef enum logic {
        CTRL_RUN      = 1'b0,
        CTRL_REDIRECT = 1'b1
    } ctrl_state_t;

    // Data memory outranks load-use, which outranks fetch.
    function automatic logic [STALL_W-1:0] stall_vec(input logic req_mem,
                                                     input logic req_id,
                                                     input logic req_if);
        if (req_mem)     return STALL_MEM;
        else if (req_id) return STALL_ID;
        else if (req_if) return STALL_IF;
        else             return STALL_NONE;
    endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-side handshake: stall requests and branch decision in, stall vector
// and PC redirect out.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic                 stallreq_if;
    logic                 stallreq_id;
    logic                 stallreq_mem;
    logic                 branch_flag;
    logic [31:0]          branch_target_address;
    logic [STALL_W-1:0]   stall;
    logic                 flush;
    logic                 pc_redirect;
    logic [31:0]          new_pc;

    modport master (
        output stallreq_if, stallreq_id, stallreq_mem, branch_flag, branch_target_address,
        input  stall, flush, pc_redirect, new_pc
    );

    modport slave (
        input  stallreq_if, stallreq_id, stallreq_mem, branch_flag, branch_target_address,
        output stall, flush, pc_redirect, new_pc
    );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stall merge, registered branch redirect with
// IF/ID flush, stall watchdog and saturating performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             CLK,
    input  logic             RST,
    pipe_ctrl_if.slave       bus,
    output logic             hang,
    output logic [CNT_W-1:0] cnt_cycle,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_flush
);

    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

    ctrl_state_t     state;
    logic            capture;
    logic            redirect_done;
    logic            wd_last;
    logic [WD_W-1:0] wd_count;

    always_comb begin
        bus.stall = stall_vec(bus.stallreq_mem, bus.stallreq_id, bus.stallreq_if);
    end

    assign capture       = (state == CTRL_RUN) && bus.branch_flag && !bus.stall[2];
    assign redirect_done = (state == CTRL_REDIRECT) && !bus.stall[0];
    // Current cycle is the TIMEOUT-th consecutive stall, so hang lands on its closing edge.
    assign wd_last       = bus.stall[0] && (wd_count == WD_W'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state           <= CTRL_RUN;
            bus.new_pc      <= ZeroWord;
            bus.pc_redirect <= 1'b0;
            bus.flush       <= 1'b0;
        end else begin
            case (state)
                CTRL_RUN: begin
                    if (capture) begin
                        state           <= CTRL_REDIRECT;
                        bus.new_pc      <= bus.branch_target_address;
                        bus.pc_redirect <= 1'b1;
                        bus.flush       <= 1'b1;
                    end
                end
                CTRL_REDIRECT: begin
                    if (redirect_done) begin
                        state           <= CTRL_RUN;
                        bus.pc_redirect <= 1'b0;
                        bus.flush       <= 1'b0;
                    end
                end
                default: begin
                    state           <= CTRL_RUN;
                    bus.pc_redirect <= 1'b0;
                    bus.flush       <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            hang <= 1'b0;
        end else if (wd_last) begin
            hang <= 1'b1;
        end
    end

    sat_counter #(.W(WD_W)) u_watchdog (
        .clk   (CLK),
        .rst_n (RST),
        .clr   (!bus.stall[0]),
        .inc   (bus.stall[0]),
        .count (wd_count)
    );

    sat_counter #(.W(CNT_W)) u_cnt_cycle (
        .clk   (CLK),
        .rst_n (RST),
        .clr   (1'b0),
        .inc   (1'b1),
        .count (cnt_cycle)
    );

    sat_counter #(.W(CNT_W)) u_cnt_stall (
        .clk   (CLK),
        .rst_n (RST),
        .clr   (1'b0),
        .inc   (bus.stall[0]),
        .count (cnt_stall)
    );

    sat_counter #(.W(CNT_W)) u_cnt_flush (
        .clk   (CLK),
        .rst_n (RST),
        .clr   (1'b0),
        .inc   (redirect_done),
        .count (cnt_flush)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: decode table, directed corner sequences and a random run
// checked against a cycle-level reference model.
module tb_pipe_ctrl;

    localparam int unsigned CNT_W   = 8;
    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CMAX    = (1 << CNT_W) - 1;

    logic             CLK = 1'b0;
    logic             RST = 1'b0;
    logic             hang;
    logic [CNT_W-1:0] cnt_cycle, cnt_stall, cnt_flush;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus),
        .hang      (hang),
        .cnt_cycle (cnt_cycle),
        .cnt_stall (cnt_stall),
        .cnt_flush (cnt_flush)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_red;
    logic [31:0] m_pc;
    int unsigned m_cyc, m_stl, m_fl, m_consec;
    bit          m_hang;

    typedef struct {
        bit         mem, id, ifr;
        logic [5:0] exp_stall;
    } dec_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] ref_stall(input bit mem, input bit id, input bit ifr);
        if (mem) return 6'b011111;
        if (id)  return 6'b000111;
        if (ifr) return 6'b000011;
        return 6'b000000;
    endfunction

    function automatic int unsigned sat_inc(input int unsigned v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic model_reset();
        m_red = 0; m_pc = '0; m_cyc = 0; m_stl = 0; m_fl = 0; m_consec = 0; m_hang = 0;
    endtask

    task automatic model_step(input bit mem, input bit id, input bit ifr,
                              input bit br, input logic [31:0] tgt);
        bit pc_hold, idex_hold;
        pc_hold   = mem | id | ifr;
        idex_hold = mem | id;
        if (m_red) begin
            if (!pc_hold) begin
                m_red = 0;
                m_fl  = sat_inc(m_fl);
            end
        end else if (br && !idex_hold) begin
            m_red = 1;
            m_pc  = tgt;
        end
        m_cyc = sat_inc(m_cyc);
        if (pc_hold) begin
            m_stl    = sat_inc(m_stl);
            m_consec = m_consec + 1;
        end else begin
            m_consec = 0;
        end
        if (m_consec >= TIMEOUT) m_hang = 1;
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".pc_redirect"}, 32'(bus.pc_redirect), 32'(m_red));
        chk({tag, ".flush"},       32'(bus.flush),       32'(m_red));
        chk({tag, ".new_pc"},      bus.new_pc,           m_pc);
        chk({tag, ".hang"},        32'(hang),            32'(m_hang));
        chk({tag, ".cnt_cycle"},   32'(cnt_cycle),       m_cyc);
        chk({tag, ".cnt_stall"},   32'(cnt_stall),       m_stl);
        chk({tag, ".cnt_flush"},   32'(cnt_flush),       m_fl);
    endtask

    // Drive one cycle of inputs, check the stall decode, clock, then check state.
    task automatic cycle(input bit mem, input bit id, input bit ifr,
                         input bit br, input logic [31:0] tgt, input string tag);
        bus.stallreq_mem = mem;
        bus.stallreq_id  = id;
        bus.stallreq_if  = ifr;
        bus.branch_flag  = br;
        bus.branch_target_address = tgt;
        #1;
        chk({tag, ".stall"}, 32'(bus.stall), 32'(ref_stall(mem, id, ifr)));
        @(posedge CLK);
        model_step(mem, id, ifr, br, tgt);
        #1;
        check_regs(tag);
    endtask

    task automatic async_reset_pulse(input string tag);
        RST = 1'b0;
        #1;
        model_reset();
        check_regs(tag);
        @(negedge CLK);
        RST = 1'b1;
    endtask

    initial begin
        dec_vec_t vecs[8];
        int unsigned fl0, st0;

        bus.stallreq_mem = 0; bus.stallreq_id = 0; bus.stallreq_if = 0;
        bus.branch_flag  = 0; bus.branch_target_address = '0;
        model_reset();

        for (int unsigned k = 0; k < 8; k++) begin
            vecs[k].mem = k[2];
            vecs[k].id  = k[1];
            vecs[k].ifr = k[0];
        end
        vecs[0].exp_stall = 6'b000000; vecs[1].exp_stall = 6'b000011;
        vecs[2].exp_stall = 6'b000111; vecs[3].exp_stall = 6'b000111;
        vecs[4].exp_stall = 6'b011111; vecs[5].exp_stall = 6'b011111;
        vecs[6].exp_stall = 6'b011111; vecs[7].exp_stall = 6'b011111;

        // Decode table applied while held in reset; registers must stay cleared.
        #2;
        for (int i = 0; i < 8; i++) begin
            bus.stallreq_mem = vecs[i].mem;
            bus.stallreq_id  = vecs[i].id;
            bus.stallreq_if  = vecs[i].ifr;
            bus.branch_flag  = 1'b1;
            bus.branch_target_address = 32'hDEAD_0000 + 32'(i);
            #3;
            chk($sformatf("table%0d.stall", i), 32'(bus.stall), 32'(vecs[i].exp_stall));
            check_regs($sformatf("table%0d", i));
        end

        @(negedge CLK);
        bus.stallreq_mem = 0; bus.stallreq_id = 0; bus.stallreq_if = 0; bus.branch_flag = 0;
        RST = 1'b1;
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, '0, "idle");
        chk("cycles_after_reset", 32'(cnt_cycle), 32'd5);

        // Unstalled branch: one-cycle redirect then drop.
        cycle(0, 0, 0, 1, 32'h0000_0100, "br");
        chk("br.new_pc_0x100", bus.new_pc, 32'h0000_0100);
        chk("br.redirect_hi", 32'(bus.pc_redirect), 32'd1);
        cycle(0, 0, 0, 0, '0, "br_done");
        chk("br_done.redirect_lo", 32'(bus.pc_redirect), 32'd0);
        chk("br_done.cnt_flush", 32'(cnt_flush), 32'd1);

        // Branch under load-use stall and under mem stall: ignored.
        fl0 = m_fl;
        cycle(0, 1, 0, 1, 32'h0000_0200, "br_id");
        chk("br_id.no_redirect", 32'(bus.pc_redirect), 32'd0);
        cycle(1, 0, 0, 1, 32'h0000_0300, "br_mem");
        chk("br_mem.no_redirect", 32'(bus.pc_redirect), 32'd0);
        cycle(0, 0, 0, 0, '0, "gap");
        chk("br_id.cnt_flush", 32'(cnt_flush), 32'(fl0));

        // Branch with only a fetch stall is still captured.
        cycle(0, 0, 1, 1, 32'h0000_0400, "br_if");
        chk("br_if.new_pc", bus.new_pc, 32'h0000_0400);
        cycle(0, 0, 0, 0, '0, "br_if_done");

        // Redirect held by 3 mem-stall cycles; branch in REDIRECT ignored.
        cycle(0, 0, 0, 1, 32'h0000_0500, "hold0");
        st0 = m_stl;
        for (int i = 0; i < 3; i++) begin
            cycle(1, 0, 0, 1, 32'h0000_0600, "hold");
            chk("hold.new_pc", bus.new_pc, 32'h0000_0500);
        end
        chk("hold.cnt_stall_delta", 32'(cnt_stall) - 32'(st0), 32'd3);
        cycle(0, 0, 0, 0, '0, "hold_last");
        chk("hold_last.redirect_lo", 32'(bus.pc_redirect), 32'd0);

        // Watchdog boundary: hang exactly after the 4th stalled edge, sticky.
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, '0, "wd");
        chk("wd.not_yet", 32'(hang), 32'd0);
        cycle(1, 0, 0, 0, '0, "wd4");
        chk("wd4.hang", 32'(hang), 32'd1);
        cycle(0, 0, 0, 0, '0, "wd_sticky");
        chk("wd_sticky.hang", 32'(hang), 32'd1);
        async_reset_pulse("wd_reset");

        // Reset asserted mid-REDIRECT clears outputs asynchronously.
        cycle(0, 0, 0, 1, 32'h0000_0700, "mid");
        @(negedge CLK);
        async_reset_pulse("mid_reset");
        cycle(0, 0, 0, 0, '0, "post_reset");

        // Random run long enough to saturate the 8-bit counters.
        for (int i = 0; i < 600; i++) begin
            bit mem, id, ifr, br;
            mem = ($urandom_range(0, 7) == 0);
            id  = ($urandom_range(0, 5) == 0);
            ifr = ($urandom_range(0, 4) == 0);
            br  = ($urandom_range(0, 2) == 0);
            cycle(mem, id, ifr, br, $urandom, "rand");
            if (i == 300) async_reset_pulse("rand_reset");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
